// File: rtl/sc_matrix_row_sequencer.sv
// Row-register bank controller: arbitrates clear / write / scroll commands and
// the periodic auto-scroll tick, and issues one-cycle active-low row strobes.
module sc_matrix_row_sequencer #(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned DATAWIDTH   = 8,
  parameter int unsigned IDXWIDTH    = 3,
  parameter int unsigned TICK_CYCLES = 25000000
) (
  input  logic                 SC_Reg_MATRIX_CLOCK_50,
  input  logic                 SC_Reg_MATRIX_RESET_InHigh,
  input  logic                 cmd_clear_In,
  input  logic                 cmd_write_In,
  input  logic [IDXWIDTH-1:0]  cmd_row_In,
  input  logic [DATAWIDTH-1:0] cmd_data_InBUS,
  input  logic                 cmd_scroll_In,
  input  logic                 autoscroll_en_In,
  output logic [ROWS-1:0]      row_clear_OutLow,
  output logic [ROWS-1:0]      row_load_OutLow,
  output logic [DATAWIDTH-1:0] row_data_OutBUS,
  output logic                 row_srcsel_Out,
  output logic                 busy_Out,
  output logic                 done_Out,
  output logic                 err_Out
);

  localparam int unsigned TICKWIDTH = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICKWIDTH-1:0] TICKLAST = TICKWIDTH'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WRITE, SCROLL, DONE} state_t;

  state_t               state;
  logic [TICKWIDTH-1:0] tickCount;
  logic                 pendingAuto;
  logic                 tickWrap;
  logic                 rowValid;
  logic [ROWS-1:0]      rowSelectMask;

  assign tickWrap = autoscroll_en_In && (tickCount == TICKLAST);
  assign rowValid = 32'(cmd_row_In) < ROWS;

  // One-hot decode of the requested write row (all zeros when out of range)
  always_comb begin
    rowSelectMask = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (32'(cmd_row_In) == 32'(r)) begin
        rowSelectMask[r] = 1'b1;
      end
    end
  end

  // Free-running auto-scroll period counter, held at zero while disabled
  always_ff @(posedge SC_Reg_MATRIX_CLOCK_50 or posedge SC_Reg_MATRIX_RESET_InHigh) begin
    if (SC_Reg_MATRIX_RESET_InHigh) begin
      tickCount <= '0;
    end else if (!autoscroll_en_In || tickWrap) begin
      tickCount <= '0;
    end else begin
      tickCount <= tickCount + TICKWIDTH'(1);
    end
  end

  // Single-deep auto-scroll request; a fresh tick outranks the service clear
  always_ff @(posedge SC_Reg_MATRIX_CLOCK_50 or posedge SC_Reg_MATRIX_RESET_InHigh) begin
    if (SC_Reg_MATRIX_RESET_InHigh) begin
      pendingAuto <= 1'b0;
    end else if (!autoscroll_en_In) begin
      pendingAuto <= 1'b0;
    end else if (tickWrap) begin
      pendingAuto <= 1'b1;
    end else if (state == SCROLL) begin
      pendingAuto <= 1'b0;
    end
  end

  // Command FSM; strobes are registered on the accepting edge so they are
  // visible for exactly the one cycle spent in CLEAR/WRITE/SCROLL
  always_ff @(posedge SC_Reg_MATRIX_CLOCK_50 or posedge SC_Reg_MATRIX_RESET_InHigh) begin
    if (SC_Reg_MATRIX_RESET_InHigh) begin
      state            <= IDLE;
      row_clear_OutLow <= '1;
      row_load_OutLow  <= '1;
      row_data_OutBUS  <= '0;
      row_srcsel_Out   <= 1'b0;
      busy_Out         <= 1'b0;
      done_Out         <= 1'b0;
      err_Out          <= 1'b0;
    end else begin
      row_clear_OutLow <= '1;
      row_load_OutLow  <= '1;
      row_srcsel_Out   <= 1'b0;
      done_Out         <= 1'b0;
      err_Out          <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_clear_In) begin
            state            <= CLEAR;
            row_clear_OutLow <= '0;
            busy_Out         <= 1'b1;
          end else if (cmd_write_In) begin
            if (rowValid) begin
              state           <= WRITE;
              row_load_OutLow <= ~rowSelectMask;
              row_data_OutBUS <= cmd_data_InBUS;
              busy_Out        <= 1'b1;
            end else begin
              err_Out <= 1'b1;
            end
          end else if (cmd_scroll_In || pendingAuto) begin
            state           <= SCROLL;
            row_load_OutLow <= '0;
            row_srcsel_Out  <= 1'b1;
            busy_Out        <= 1'b1;
          end
        end
        CLEAR, WRITE, SCROLL: begin
          state    <= DONE;
          done_Out <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          busy_Out <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_matrix_row_sequencer.sv
// Directed bench for sc_matrix_row_sequencer (ROWS=8, IDXWIDTH=4, TICK_CYCLES=4).
module tb_sc_matrix_row_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmdClear = 1'b0;
  logic       cmdWrite = 1'b0;
  logic [3:0] cmdRow = '0;
  logic [7:0] cmdData = '0;
  logic       cmdScroll = 1'b0;
  logic       autoEn = 1'b0;
  logic [7:0] rowClear;
  logic [7:0] rowLoad;
  logic [7:0] rowData;
  logic       srcSel;
  logic       busy;
  logic       done;
  logic       err;

  int nAsserts = 0;
  int nFails   = 0;

  sc_matrix_row_sequencer #(
    .ROWS(8), .DATAWIDTH(8), .IDXWIDTH(4), .TICK_CYCLES(4)
  ) dut (
    .SC_Reg_MATRIX_CLOCK_50    (clk),
    .SC_Reg_MATRIX_RESET_InHigh(rst),
    .cmd_clear_In              (cmdClear),
    .cmd_write_In              (cmdWrite),
    .cmd_row_In                (cmdRow),
    .cmd_data_InBUS            (cmdData),
    .cmd_scroll_In             (cmdScroll),
    .autoscroll_en_In          (autoEn),
    .row_clear_OutLow          (rowClear),
    .row_load_OutLow           (rowLoad),
    .row_data_OutBUS           (rowData),
    .row_srcsel_Out            (srcSel),
    .busy_Out                  (busy),
    .done_Out                  (done),
    .err_Out                   (err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    #2 rst = 1'b1;
    step();
    step();
    check("rst_clear", 32'(rowClear), 32'hFF);
    check("rst_load", 32'(rowLoad), 32'hFF);
    check("rst_data", 32'(rowData), 32'h00);
    check("rst_srcsel", 32'(srcSel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    step();

    // Single write to row 5; later input changes must not leak in
    cmdWrite = 1'b1; cmdRow = 4'd5; cmdData = 8'hA5;
    step();
    check("wr_load", 32'(rowLoad), 32'hDF);
    check("wr_data", 32'(rowData), 32'hA5);
    check("wr_srcsel", 32'(srcSel), 32'h0);
    check("wr_busy", 32'(busy), 32'h1);
    check("wr_nodone", 32'(done), 32'h0);
    cmdRow = 4'd2; cmdData = 8'h3C;
    step();
    check("wr_done", 32'(done), 32'h1);
    check("wr_done_load", 32'(rowLoad), 32'hFF);
    check("wr_done_busy", 32'(busy), 32'h1);
    cmdWrite = 1'b0;
    step();
    check("wr_idle_done", 32'(done), 32'h0);
    check("wr_idle_busy", 32'(busy), 32'h0);

    // Clear and scroll together: clear first, then the held scroll
    cmdClear = 1'b1; cmdScroll = 1'b1;
    step();
    check("cs_clear", 32'(rowClear), 32'h00);
    check("cs_clear_load", 32'(rowLoad), 32'hFF);
    check("cs_clear_busy", 32'(busy), 32'h1);
    step();
    check("cs_clear_done", 32'(done), 32'h1);
    check("cs_clear_off", 32'(rowClear), 32'hFF);
    cmdClear = 1'b0;
    step();
    check("cs_gap_busy", 32'(busy), 32'h0);
    check("cs_gap_load", 32'(rowLoad), 32'hFF);
    step();
    check("cs_scroll_load", 32'(rowLoad), 32'h00);
    check("cs_scroll_sel", 32'(srcSel), 32'h1);
    check("cs_scroll_clear", 32'(rowClear), 32'hFF);
    cmdScroll = 1'b0;
    step();
    check("cs_scroll_done", 32'(done), 32'h1);
    step();
    check("cs_end_busy", 32'(busy), 32'h0);

    // Out-of-range write row
    cmdWrite = 1'b1; cmdRow = 4'd9; cmdData = 8'h99;
    step();
    check("err_pulse", 32'(err), 32'h1);
    check("err_busy", 32'(busy), 32'h0);
    check("err_load", 32'(rowLoad), 32'hFF);
    check("err_clear", 32'(rowClear), 32'hFF);
    cmdWrite = 1'b0;
    step();
    check("err_end", 32'(err), 32'h0);
    check("err_nodone", 32'(done), 32'h0);
    check("err_end_busy", 32'(busy), 32'h0);

    // Auto-scroll every 4 cycles while idle
    autoEn = 1'b1;
    repeat (4) step();
    check("tk_wrap_idle", 32'(rowLoad), 32'hFF);
    step();
    check("tk_scroll1", 32'(rowLoad), 32'h00);
    check("tk_scroll1_sel", 32'(srcSel), 32'h1);
    step();
    check("tk_done1", 32'(done), 32'h1);
    step();
    check("tk_idle1", 32'(busy), 32'h0);
    step();
    check("tk_idle2", 32'(rowLoad), 32'hFF);
    step();
    check("tk_scroll2", 32'(rowLoad), 32'h00);
    autoEn = 1'b0;
    step();
    check("tk_done2", 32'(done), 32'h1);
    step();

    // Write held 10 cycles with auto-scroll: one pending scroll, extra ticks dropped
    autoEn = 1'b1; cmdWrite = 1'b1; cmdRow = 4'd3; cmdData = 8'h5A;
    step();
    check("hw_first_load", 32'(rowLoad), 32'hF7);
    repeat (8) step();
    step();
    check("hw_last_load", 32'(rowLoad), 32'hF7);
    check("hw_last_data", 32'(rowData), 32'h5A);
    cmdWrite = 1'b0;
    step();
    check("hw_done", 32'(done), 32'h1);
    step();
    check("hw_idle_busy", 32'(busy), 32'h0);
    check("hw_idle_load", 32'(rowLoad), 32'hFF);
    step();
    check("hw_auto_load", 32'(rowLoad), 32'h00);
    check("hw_auto_sel", 32'(srcSel), 32'h1);
    step();
    check("hw_auto_done", 32'(done), 32'h1);
    step();
    check("hw_drop1", 32'(rowLoad), 32'hFF);
    step();
    check("hw_drop2", 32'(rowLoad), 32'hFF);
    check("hw_drop2_busy", 32'(busy), 32'h0);
    step();
    check("hw_next_auto", 32'(rowLoad), 32'h00);
    autoEn = 1'b0;
    step();
    step();

    // Disabling auto-scroll while busy discards the pending scroll
    autoEn = 1'b1; cmdWrite = 1'b1; cmdRow = 4'd0; cmdData = 8'h77;
    step();
    check("de_first_load", 32'(rowLoad), 32'hFE);
    repeat (3) step();
    check("de_second_load", 32'(rowLoad), 32'hFE);
    cmdWrite = 1'b0; autoEn = 1'b0;
    step();
    check("de_done", 32'(done), 32'h1);
    step();
    check("de_idle_load", 32'(rowLoad), 32'hFF);
    check("de_idle_busy", 32'(busy), 32'h0);
    step();
    check("de_noscroll1", 32'(rowLoad), 32'hFF);
    step();
    check("de_noscroll2", 32'(rowLoad), 32'hFF);
    check("de_noscroll_busy", 32'(busy), 32'h0);

    // Reset asserted in the middle of a SCROLL cycle
    cmdScroll = 1'b1;
    step();
    check("rs_scroll_load", 32'(rowLoad), 32'h00);
    cmdScroll = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rs_async_load", 32'(rowLoad), 32'hFF);
    check("rs_async_busy", 32'(busy), 32'h0);
    check("rs_async_sel", 32'(srcSel), 32'h0);
    step();
    rst = 1'b0;
    step();
    check("rs_after_done", 32'(done), 32'h0);
    check("rs_after_busy", 32'(busy), 32'h0);
    cmdWrite = 1'b1; cmdRow = 4'd1; cmdData = 8'h11;
    step();
    check("rs_accept_load", 32'(rowLoad), 32'hFD);
    check("rs_accept_data", 32'(rowData), 32'h11);
    cmdWrite = 1'b0;
    step();
    check("rs_accept_done", 32'(done), 32'h1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sc_matrix_row_sequencer.md
Name: sc_matrix_row_sequencer

Overview:
- Controller for a bank of ROWS matrix row registers (clear_InLow / load0_InLow style, hold-when-idle).
- Accepts clear-all, single-row-write and scroll-down commands, plus an internal periodic auto-scroll tick.
- Arbitrates these commands and issues one-cycle active-low clear/load strobes, a shared write data bus and a row-source select toward the row registers and their input muxes.

Parameters:
- ROWS, 8, number of row registers controlled (2..16).
- DATAWIDTH, 8, row width in bits.
- IDXWIDTH, 3, row index width; must satisfy 2^IDXWIDTH >= ROWS.
- TICK_CYCLES, 25000000, auto-scroll period in clock cycles (>= 4).

Ports:
- SC_Reg_MATRIX_CLOCK_50  in  1  system clock; all state updates on its rising edge.
- SC_Reg_MATRIX_RESET_InHigh  in  1  reset; asynchronous, active-high.
- cmd_clear_In  in  1  request clear-all (level; sampled in IDLE).
- cmd_write_In  in  1  request write of cmd_data_InBUS into row cmd_row_In.
- cmd_row_In  in  IDXWIDTH  target row for a write.
- cmd_data_InBUS  in  DATAWIDTH  write data.
- cmd_scroll_In  in  1  request scroll-down.
- autoscroll_en_In  in  1  enables the periodic tick.
- row_clear_OutLow  out  ROWS  per-row clear strobe, active-low.
- row_load_OutLow  out  ROWS  per-row load strobe, active-low.
- row_data_OutBUS  out  DATAWIDTH  data toward the row input muxes.
- row_srcsel_Out  out  1  mux select: 0 = row_data_OutBUS, 1 = row above (row 0 gets all-zero).
- busy_Out  out  1  high while a command is executing.
- done_Out  out  1  one-cycle pulse when a command completes.
- err_Out  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset (async): FSM = IDLE, tick counter = 0, pending_auto = 0. row_clear_OutLow and row_load_OutLow all ones. row_data_OutBUS = 0. row_srcsel_Out = 0. busy_Out, done_Out and err_Out = 0.
- All outputs are registered.
- States: IDLE, CLEAR, WRITE, SCROLL, DONE.
- IDLE arbitration, fixed priority: clear > write > external scroll > pending_auto. Exactly one command is accepted per IDLE cycle.
  - Unaccepted external requests are not remembered. They must be held until done_Out.
  - pending_auto is remembered until serviced.
- CLEAR (1 cycle): row_clear_OutLow = all zeros.
- WRITE (1 cycle):
  - row_load_OutLow[cmd_row_In] = 0, all other bits 1.
  - row_data_OutBUS = cmd_data_InBUS, row_srcsel_Out = 0.
  - Row index and data are captured on acceptance. Later input changes are ignored.
- SCROLL (1 cycle): row_load_OutLow = all zeros, row_srcsel_Out = 1.
  - Each row r loads row r-1; row 0 loads zero.
  - Servicing a scroll in this state clears pending_auto whether the scroll came from cmd_scroll_In or pending_auto.
- DONE (1 cycle):
  - done_Out = 1, strobes deasserted, busy_Out = 0 on the next cycle; return to IDLE.
  - busy_Out = 1 in CLEAR, WRITE, SCROLL and DONE.
- Latency: request seen in IDLE at edge N; strobe visible cycles N+1..N+1; done_Out in cycle N+2; the next command can be accepted at edge N+3.
- Write with cmd_row_In >= ROWS:
  - No state change beyond a one-cycle err_Out pulse. No strobes and no done_Out.
  - FSM stays in IDLE, and lower-priority requests are not served that cycle.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 while autoscroll_en_In = 1 and wraps to 0.
  - The wrap sets pending_auto = 1; if pending_auto is already set, the extra tick is dropped (no queue depth).
  - Deasserting autoscroll_en_In resets the counter to 0 and clears pending_auto.
  - The counter runs regardless of FSM state.
- Simultaneous clear + scroll: clear wins. The scroll is lost unless held, or pending_auto remains for auto.
- Reset mid-command: strobes return to inactive asynchronously and the command is abandoned.
- Strobe outputs never have more than one command type active in the same cycle.

Test Plan:
- Reset asserted mid-SCROLL -> row_load_OutLow = 8'hFF immediately, busy_Out = 0, FSM IDLE after release, no done_Out.
- cmd_write_In = 1, cmd_row_In = 5, data 8'hA5 -> one cycle with row_load_OutLow = 8'hDF and row_data_OutBUS = 8'hA5, srcsel = 0, done_Out pulse next cycle.
- cmd_clear_In and cmd_scroll_In asserted together for 4 cycles -> CLEAR strobe (row_clear_OutLow = 8'h00), done, then SCROLL strobe (row_load_OutLow = 8'h00, srcsel = 1), done.
- cmd_write_In with cmd_row_In = 9, ROWS = 8, IDXWIDTH = 4 -> single err_Out pulse, no strobes, busy_Out stays 0.
- TICK_CYCLES = 4, autoscroll_en_In = 1, idle -> SCROLL strobe every 4 cycles. With a write held for 10 cycles, the pending scroll executes right after the write's DONE, and the second tick during busy is dropped.
- autoscroll_en_In dropped while pending_auto = 1 and FSM busy -> no scroll after return to IDLE.
